frame_ram_arbiter: RTL and testbench
====================================

Name: frame_ram_arbiter

Overview:
- Owns the single port of the 4800x3 frame RAM (80x60 grid of 8x8 cells, 3-bit sprite index per cell) and shares it between two users:
  - the video scan-out reader, which has absolute priority;
  - game-logic cell writes (head/tail sprite updates, food, erase), buffered in a small queue.
- Includes a clear engine that sweeps every cell to a fixed value after reset or on request, e.g. at game restart.
- Sits between the snake game logic, the pixel pipeline and the sram instance.

Parameters:
- DEPTH, 4800, number of frame RAM cells; valid addresses are 0..DEPTH-1.
- AW, 13, address width.
- DW, 3, data width (sprite index).
- QDEPTH, 4, write queue entries; must be a power of 2.
- CLEAR_VAL, 0, value written by the clear sweep.
- CLEAR_ON_RESET, 1, when 1 a clear sweep starts automatically when reset is released.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- rd_req  in  1  scan-out read request this cycle.
- rd_addr  in  AW  scan-out cell address.
- rd_data  out  DW  read data, equal to ram_rdata.
- rd_valid  out  1  high one cycle after a granted rd_req.
- wr_valid  in  1  game write request.
- wr_addr  in  AW  cell to write.
- wr_data  in  DW  sprite index to write.
- wr_ready  out  1  high when the queue is not full.
- clear_req  in  1  single-cycle pulse that starts a clear sweep.
- busy  out  1  high while a clear sweep is in progress.
- clear_done  out  1  one-cycle pulse when a sweep completes.
- drop_err  out  1  sticky flag: an out-of-range write was discarded.
- ram_addr  out  AW  to sram i_addr.
- ram_write  out  1  to sram i_write.
- ram_wdata  out  DW  to sram i_data.
- ram_rdata  in  DW  from sram o_data (registered, 1-cycle read latency).

Behaviour:
- Reset (asynchronous, while rstn=0): queue emptied; clear counter=0; rd_valid=0; clear_done=0; drop_err=0; busy=0; wr_ready=1.
- Reset also forces the combinational RAM outputs to 0: ram_write=0, ram_addr=0, ram_wdata=0.
- State after reset: FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset mid-sweep or mid-queue aborts everything: queued writes are lost and any sweep restarts from address 0.
- FSM states:
  - IDLE: drains the queue.
  - CLEAR: sweeps the frame.
  - IDLE -> CLEAR on clear_req.
  - CLEAR -> IDLE in the cycle after the write to address DEPTH-1.
- Per-cycle RAM port priority (combinational select):
  1. rd_req: ram_addr=rd_addr, ram_write=0.
  2. CLEAR: ram_addr=clear counter, ram_wdata=CLEAR_VAL, ram_write=1; counter increments.
  3. IDLE with queue non-empty: pop the head entry, ram_addr=entry addr, ram_wdata=entry data, ram_write=1.
  4. Otherwise: ram_write=0, ram_addr=rd_addr.
- A read always wins. Clear and queue writes only advance in cycles where rd_req=0; the clear counter holds during reads.
- rd_valid is registered and equals the previous cycle's rd_req. rd_data always equals ram_rdata.
- Write queue:
  - Push on wr_valid & wr_ready. wr_ready = !full; it does not account for a same-cycle pop.
  - Push and pop in the same cycle are both performed.
  - An entry pushed in cycle N is written to RAM no earlier than cycle N+1.
  - Entries are written in FIFO order.
  - The queue accepts pushes during CLEAR but does not drain until IDLE, so queued writes land on top of the cleared frame.
- Out-of-range writes (wr_addr >= DEPTH) are accepted, then discarded when popped, with no RAM write; drop_err is set and held until reset.
- clear_req handling:
  - Ignored while already in CLEAR; the sweep does not restart.
  - clear_req in IDLE with a non-empty queue enters CLEAR immediately; pending writes are held.
- busy is registered and high for the whole CLEAR state.
- clear_done is registered, one cycle wide, and asserted in the cycle the FSM returns to IDLE.
- Minimum sweep length is DEPTH cycles; each cycle with rd_req=1 during the sweep adds one cycle.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=4800, rd_req=0 -> busy high for exactly 4800 cycles, addresses 0..4799 written with 0, clear_done pulses once, then busy=0.
- Sweep with rd_req=1 on alternate cycles -> sweep takes 9600 cycles, every read cycle shows ram_write=0, and rd_valid follows rd_req delayed by 1 cycle.
- In IDLE, push 5 writes back-to-back with rd_req=0 (addr 100..104, data 1..5) -> wr_ready never drops; RAM writes to 100..104 in order, each one cycle after its push.
- Hold rd_req=1 and push 5 writes -> wr_ready=0 after the 4th push; release rd_req -> 4 queued writes drain in order, then the 5th is accepted.
- Push a write to addr 4800 -> no RAM write, drop_err=1 and held; a subsequent write to addr 4799 data 7 is written normally.
- Push addr 10 data 3, then clear_req before it drains -> busy, full sweep, then addr 10 written with 3 after clear_done. A clear_req during the sweep has no effect. Assert rstn=0 mid-sweep -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: scan-out reads always win, the clear sweep comes
// next, and buffered game writes drain from a small FIFO when the port is otherwise free.
module frame_ram_arbiter #(
  parameter int DEPTH          = 4800,
  parameter int AW             = 13,
  parameter int DW             = 3,
  parameter int QDEPTH         = 4,
  parameter int CLEAR_VAL      = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          px_clk,
  input  logic          rstn,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_done,
  output logic          drop_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int PW = $clog2(QDEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_clrCnt;
  logic [AW-1:0] r_qAddr [QDEPTH];
  logic [DW-1:0] r_qData [QDEPTH];
  logic [PW:0]   r_wrPtr;
  logic [PW:0]   r_rdPtr;
  logic          r_rdValid;
  logic          r_clearDone;
  logic          r_dropErr;

  logic [PW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_clrStep;
  logic          w_clrLast;
  logic [AW-1:0] w_headAddr;
  logic [DW-1:0] w_headData;
  logic          w_headOk;

  assign w_count    = r_wrPtr - r_rdPtr;
  assign w_full     = (w_count == (PW+1)'(QDEPTH));
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_push     = wr_valid && !w_full;
  assign w_headAddr = r_qAddr[r_rdPtr[PW-1:0]];
  assign w_headData = r_qData[r_rdPtr[PW-1:0]];
  assign w_headOk   = ({1'b0, w_headAddr} < (AW+1)'(DEPTH));
  assign w_clrLast  = (r_clrCnt == AW'(DEPTH-1));

  // A clear request in IDLE takes effect at once, so the queue must not pop that cycle.
  always_comb begin
    w_nextState = r_state;
    w_clrStep   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_nextState = S_CLEAR;
        end else if (!rd_req && !w_empty) begin
          w_pop = 1'b1;
        end
      end
      S_CLEAR: begin
        if (!rd_req) begin
          w_clrStep = 1'b1;
          if (w_clrLast) begin
            w_nextState = S_IDLE;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_write = 1'b0;
    ram_wdata = '0;
    if (rstn) begin
      ram_addr = rd_addr;
      if (!rd_req) begin
        if (w_clrStep) begin
          ram_addr  = r_clrCnt;
          ram_write = 1'b1;
          ram_wdata = DW'(CLEAR_VAL);
        end else if (w_pop && w_headOk) begin
          ram_addr  = w_headAddr;
          ram_write = 1'b1;
          ram_wdata = w_headData;
        end
      end
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_clrCnt    <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_rdValid   <= 1'b0;
      r_clearDone <= 1'b0;
      r_dropErr   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_rdValid   <= rd_req;
      r_clearDone <= (r_state == S_CLEAR) && (w_nextState == S_IDLE);
      if (w_clrStep) begin
        r_clrCnt <= w_clrLast ? '0 : r_clrCnt + 1'b1;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        if (!w_headOk) begin
          r_dropErr <= 1'b1;
        end
      end
    end
  end

  // Queue storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge px_clk) begin
    if (w_push) begin
      r_qAddr[r_wrPtr[PW-1:0]] <= wr_addr;
      r_qData[r_wrPtr[PW-1:0]] <= wr_data;
    end
  end

  assign rd_data    = ram_rdata;
  assign rd_valid   = r_rdValid;
  assign wr_ready   = !w_full;
  assign busy       = rstn && (r_state == S_CLEAR);
  assign clear_done = r_clearDone;
  assign drop_err   = r_dropErr;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Randomised and directed bench for frame_ram_arbiter, checked every cycle against a
// queue-based reference of the port-sharing rules and a shadow copy of the frame RAM.
module tb_frame_ram_arbiter;

  localparam int DEPTH = 4800;
  localparam int AW    = 13;
  localparam int DW    = 3;

  logic          px_clk = 1'b0;
  logic          rstn   = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          clear_req = 1'b0;
  logic          busy;
  logic          clear_done;
  logic          drop_err;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  frame_ram_arbiter dut (
    .px_clk(px_clk), .rstn(rstn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .drop_err(drop_err),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 px_clk = ~px_clk;

  // Environment SRAM with registered read, as the real instance behaves.
  logic [DW-1:0] sram [8192];
  always @(posedge px_clk) begin
    if (ram_write) sram[ram_addr] <= ram_wdata;
    ram_rdata <= sram[ram_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           mQueue[$];
  bit            mSweep;
  int            mIdx;
  bit            mDrop;
  bit            mPrevRd;
  bit            mDone;
  logic [DW-1:0] mReadVal;
  logic [DW-1:0] expMem [8192];

  int            checks;
  int            errors;
  logic          lastBusy;
  logic          lastDone;
  logic          lastReady;
  logic          lastDrop;
  logic [DW-1:0] lastRdData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the reference.
  task automatic applyStimulus(input bit rq, input logic [AW-1:0] ra, input bit wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input bit cr, output bit accepted);
    bit            expWrite;
    bit            addrKnown;
    bit            pop;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    wr_t           e;
    rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd; clear_req = cr;
    #1;
    lastBusy = busy; lastDone = clear_done; lastReady = wr_ready;
    lastDrop = drop_err; lastRdData = rd_data;
    checkOutput("rd_valid", rd_valid, mPrevRd);
    if (mPrevRd) checkOutput("rd_data", rd_data, mReadVal);
    checkOutput("busy", busy, mSweep);
    checkOutput("clear_done", clear_done, mDone);
    checkOutput("drop_err", drop_err, mDrop);
    checkOutput("wr_ready", wr_ready, mQueue.size() < 4);
    expWrite = 0; addrKnown = 1; pop = 0; expAddr = ra; expData = '0;
    if (rq) begin
    end else if (mSweep) begin
      expWrite = 1; expAddr = mIdx[AW-1:0]; expData = '0;
    end else if (mQueue.size() > 0 && !cr) begin
      pop = 1;
      if (int'(mQueue[0].a) < DEPTH) begin
        expWrite = 1; expAddr = mQueue[0].a; expData = mQueue[0].d;
      end else begin
        addrKnown = 0;
      end
    end
    checkOutput("ram_write", ram_write, expWrite);
    if (addrKnown) checkOutput("ram_addr", ram_addr, expAddr);
    if (expWrite) checkOutput("ram_wdata", ram_wdata, expData);
    accepted = wv && (mQueue.size() < 4);
    if (rq) mReadVal = expMem[ra];
    if (expWrite) expMem[expAddr] = expData;
    if (pop) begin
      if (int'(mQueue[0].a) >= DEPTH) mDrop = 1;
      void'(mQueue.pop_front());
    end
    if (accepted) begin
      e.a = wa; e.d = wd;
      mQueue.push_back(e);
    end
    mDone = 0;
    if (mSweep && !rq) begin
      mIdx++;
      if (mIdx == DEPTH) begin
        mSweep = 0; mIdx = 0; mDone = 1;
      end
    end else if (!mSweep && cr) begin
      mSweep = 1;
    end
    mPrevRd = rq;
    @(posedge px_clk);
    @(negedge px_clk);
  endtask

  task automatic doReset();
    rd_req = 1'b1; rd_addr = 13'd5; wr_valid = 1'b1; wr_addr = 13'd9; clear_req = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_drop_err", drop_err, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_ram_write", ram_write, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_wdata", ram_wdata, 0);
    @(posedge px_clk);
    @(negedge px_clk);
    rd_req = 1'b0; wr_valid = 1'b0;
    rstn = 1'b1;
    mQueue.delete();
    mSweep = 1; mIdx = 0; mDrop = 0; mPrevRd = 0; mDone = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busyCyc;
    int doneCnt;
    bit acc;
    checks = 0; errors = 0;
    @(negedge px_clk);

    $display("[TB] reset and boot sweep");
    doReset();
    busyCyc = 0; doneCnt = 0;
    for (int i = 0; i < 6000 && doneCnt == 0; i++) begin
      applyStimulus(0, '0, 0, '0, '0, 0, acc);
      if (lastBusy) busyCyc++;
      if (lastDone) doneCnt++;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 0, '0, '0, 0, acc);
      if (lastDone) doneCnt++;
    end
    checkOutput("boot_sweep_len", busyCyc, 4800);
    checkOutput("boot_done_pulses", doneCnt, 1);
    checkOutput("boot_busy_after", lastBusy, 0);

    $display("[TB] sweep with alternating reads");
    applyStimulus(0, '0, 0, '0, '0, 1, acc);
    busyCyc = 0; doneCnt = 0;
    for (int i = 0; i < 12000 && doneCnt == 0; i++) begin
      applyStimulus((i % 2) == 0, 13'($urandom_range(0, DEPTH-1)), 0, '0, '0, 0, acc);
      if (lastBusy) busyCyc++;
      if (lastDone) doneCnt++;
    end
    checkOutput("alt_sweep_len", busyCyc, 9600);

    $display("[TB] back-to-back writes");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, '0, 1, 13'(100 + k), 3'(k + 1), 0, acc);
      checkOutput("burst_ready", lastReady, 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, '0, 0, acc);

    $display("[TB] writes held off by reads");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 13'($urandom_range(0, DEPTH-1)), 1, 13'(200 + k), 3'(k + 2), 0, acc);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 13'($urandom_range(0, DEPTH-1)), 1, 13'd204, 3'd6, 0, acc);
      checkOutput("full_ready", lastReady, 0);
    end
    acc = 0;
    for (int k = 0; k < 10 && !acc; k++) applyStimulus(0, '0, 1, 13'd204, 3'd6, 0, acc);
    checkOutput("fifth_accepted", acc, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, '0, 0, '0, '0, 0, acc);

    $display("[TB] out-of-range write");
    applyStimulus(0, '0, 1, 13'd4800, 3'd1, 0, acc);
    for (int i = 0; i < 2; i++) applyStimulus(0, '0, 0, '0, '0, 0, acc);
    checkOutput("drop_set", lastDrop, 1);
    applyStimulus(0, '0, 1, 13'd4799, 3'd7, 0, acc);
    for (int i = 0; i < 2; i++) applyStimulus(0, '0, 0, '0, '0, 0, acc);
    applyStimulus(1, 13'd4799, 0, '0, '0, 0, acc);
    applyStimulus(0, '0, 0, '0, '0, 0, acc);
    checkOutput("read_4799", lastRdData, 7);
    checkOutput("drop_held", lastDrop, 1);

    $display("[TB] queued write across a clear");
    applyStimulus(0, '0, 1, 13'd10, 3'd3, 0, acc);
    applyStimulus(0, '0, 0, '0, '0, 1, acc);
    busyCyc = 0; doneCnt = 0;
    for (int i = 0; i < 6000 && doneCnt == 0; i++) begin
      applyStimulus(0, '0, 0, '0, '0, i == 50, acc);
      if (lastBusy) busyCyc++;
      if (lastDone) doneCnt++;
    end
    checkOutput("reclear_ignored_len", busyCyc, 4800);
    applyStimulus(1, 13'd10, 0, '0, '0, 0, acc);
    applyStimulus(0, '0, 0, '0, '0, 0, acc);
    checkOutput("read_10", lastRdData, 3);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 13'($urandom_range(0, DEPTH-1)),
                    $urandom_range(0, 3) != 0, 13'($urandom_range(0, DEPTH + 10)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 999) == 0, acc);
    end
    for (int i = 0; i < 12000 && (mSweep || mQueue.size() > 0); i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 13'($urandom_range(0, DEPTH-1)), 0, '0, '0, 0, acc);
    end

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(0, '0, 0, '0, '0, 1, acc);
    for (int i = 0; i < 100; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 13'($urandom_range(0, DEPTH-1)),
                    1, 13'($urandom_range(0, DEPTH-1)), 3'($urandom_range(0, 7)), 0, acc);
    end
    doReset();
    busyCyc = 0; doneCnt = 0;
    for (int i = 0; i < 6000 && doneCnt == 0; i++) begin
      applyStimulus(0, '0, 0, '0, '0, 0, acc);
      if (lastBusy) busyCyc++;
      if (lastDone) doneCnt++;
    end
    checkOutput("post_reset_sweep_len", busyCyc, 4800);
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, '0, '0, 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
